// File: rtl/dmem_pkg.sv
// dmem_pkg: shared constants, types and helpers for the data-memory responder.
//   DMEM_ADDR_WIDTH / DMEM_DATA_WIDTH / DMEM_WB_DEPTH : default geometry.
//   wb_entry_t  : one posted-store slot {valid, addr, data}.
//   even_parity : parity bit that makes the total number of ones even.
package dmem_pkg;

  localparam int unsigned DMEM_ADDR_WIDTH = 12;
  localparam int unsigned DMEM_DATA_WIDTH = 32;
  localparam int unsigned DMEM_WB_DEPTH   = 2;

  typedef struct packed {
    logic                       valid;
    logic [DMEM_ADDR_WIDTH-1:0] addr;
    logic [DMEM_DATA_WIDTH-1:0] data;
  } wb_entry_t;

  function automatic logic even_parity(input logic [DMEM_DATA_WIDTH-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/dmem_if.sv
// dmem_if: memory-stage bus between the pipeline (master) and the responder (slave).
//   address_dmem, d_dmem, wren, rden : request from the pipeline.
//   q_dmem, q_valid, parity_err      : registered load response.
//   stall                            : store not accepted this cycle.
interface dmem_if
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DMEM_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DMEM_DATA_WIDTH
);
  logic [ADDR_WIDTH-1:0] address_dmem;
  logic [DATA_WIDTH-1:0] d_dmem;
  logic                  wren;
  logic                  rden;
  logic [DATA_WIDTH-1:0] q_dmem;
  logic                  q_valid;
  logic                  stall;
  logic                  parity_err;

  modport master (
    output address_dmem, d_dmem, wren, rden,
    input  q_dmem, q_valid, stall, parity_err
  );

  modport slave (
    input  address_dmem, d_dmem, wren, rden,
    output q_dmem, q_valid, stall, parity_err
  );
endinterface

// File: rtl/dmem_write_buffer.sv
// dmem_write_buffer: posted-store FIFO with parallel address lookup.
//   clock, reset          : clock and synchronous active-high reset.
//   push_i/_addr_i/_data_i: enqueue a store at the tail (caller guarantees not full).
//   pop_i                 : dequeue the oldest entry (ignored when empty).
//   lookup_addr_i         : load address compared against all valid entries.
//   full_o, count_o       : occupancy.
//   head_addr_o/_data_o   : oldest entry, the next one to drain.
//   hit_o, hit_data_o     : lookup result; youngest matching entry wins.
module dmem_write_buffer
  import dmem_pkg::*;
#(
  parameter int unsigned WB_DEPTH = DMEM_WB_DEPTH
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic [DMEM_ADDR_WIDTH-1:0] push_addr_i,
  input  logic [DMEM_DATA_WIDTH-1:0] push_data_i,
  input  logic                       pop_i,
  input  logic [DMEM_ADDR_WIDTH-1:0] lookup_addr_i,
  output logic                       full_o,
  output logic [$clog2(WB_DEPTH):0]  count_o,
  output logic [DMEM_ADDR_WIDTH-1:0] head_addr_o,
  output logic [DMEM_DATA_WIDTH-1:0] head_data_o,
  output logic                       hit_o,
  output logic [DMEM_DATA_WIDTH-1:0] hit_data_o
);
  localparam int unsigned PTR_W = $clog2(WB_DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(WB_DEPTH);

  wb_entry_t        entries_q [WB_DEPTH];
  wb_entry_t        entries_d [WB_DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d, idx_s;
  logic [PTR_W:0]   count_q, count_d;
  logic             pop_s;

  assign pop_s       = pop_i & (count_q != '0);
  assign full_o      = (count_q == FULL_CNT);
  assign count_o     = count_q;
  assign head_addr_o = entries_q[head_q].addr;
  assign head_data_o = entries_q[head_q].data;

  // Next state for the entry storage, pointers and occupancy count.
  always_comb begin
    entries_d = entries_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    if (push_i) begin
      entries_d[tail_q] = '{valid: 1'b1, addr: push_addr_i, data: push_data_i};
      tail_d            = tail_q + 1'b1;
    end else begin
      tail_d = tail_q;
    end
    if (pop_s) begin
      entries_d[head_q].valid = 1'b0;
      head_d                  = head_q + 1'b1;
    end else begin
      head_d = head_q;
    end
    case ({push_i, pop_s})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Scan oldest to youngest so the last match seen is the youngest store.
  always_comb begin
    hit_o      = 1'b0;
    hit_data_o = '0;
    idx_s      = head_q;
    for (int unsigned i = 0; i < WB_DEPTH; i++) begin
      idx_s = head_q + i[PTR_W-1:0];
      if (entries_q[idx_s].valid && (entries_q[idx_s].addr == lookup_addr_i)) begin
        hit_o      = 1'b1;
        hit_data_o = entries_q[idx_s].data;
      end else begin
        hit_o      = hit_o;
      end
    end
  end

  // State registers; reset discards every posted store.
  always_ff @(posedge clock) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < WB_DEPTH; i++) begin
        entries_q[i] <= '0;
      end
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      entries_q <= entries_d;
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: single-port data memory with a posted write buffer.
//   clock, reset : clock and synchronous active-high reset.
//   bus (slave)  : address_dmem, d_dmem, wren, rden in; q_dmem, q_valid,
//                  stall, parity_err out.
// Loads own the array port; queued stores drain only in cycles without rden.
// Optional feature macro: DMEM_PARITY_EN (stores an even-parity bit per word
// and flags mismatches on array-sourced loads).
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DMEM_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DMEM_DATA_WIDTH,
  parameter int unsigned WB_DEPTH   = DMEM_WB_DEPTH
) (
  input  logic  clock,
  input  logic  reset,
  dmem_if.slave bus
);
`ifdef DMEM_PARITY_EN
  localparam int unsigned MEM_W = DATA_WIDTH + 1;
`else
  localparam int unsigned MEM_W = DATA_WIDTH;
`endif

  // Array contents are deliberately not reset.
  logic [MEM_W-1:0] mem_q [0:(2**ADDR_WIDTH)-1];

  logic                        full_s, hit_s, push_s, pop_s, load_s;
  logic [$clog2(WB_DEPTH):0]   count_s;
  logic [ADDR_WIDTH-1:0]       head_addr_s;
  logic [DATA_WIDTH-1:0]       head_data_s, hit_data_s;
  logic [MEM_W-1:0]            rd_word_s, wr_word_s;
  logic [DATA_WIDTH-1:0]       q_dmem_q, q_dmem_d;
  logic                        q_valid_q, q_valid_d;

  // A store beats a load in the same cycle; a load blocks draining even when
  // it is itself ignored, so a full buffer stays stalled while rden is high.
  assign bus.stall = bus.wren & full_s;
  assign push_s    = bus.wren & ~full_s;
  assign load_s    = bus.rden & ~bus.wren;
  assign pop_s     = ~bus.rden & (count_s != '0) & ~reset;
  assign rd_word_s = mem_q[bus.address_dmem];

`ifdef DMEM_PARITY_EN
  assign wr_word_s = {even_parity(head_data_s), head_data_s};
`else
  assign wr_word_s = head_data_s;
`endif

  dmem_write_buffer #(.WB_DEPTH(WB_DEPTH)) u_wb (
    .clock         (clock),
    .reset         (reset),
    .push_i        (push_s),
    .push_addr_i   (bus.address_dmem),
    .push_data_i   (bus.d_dmem),
    .pop_i         (pop_s),
    .lookup_addr_i (bus.address_dmem),
    .full_o        (full_s),
    .count_o       (count_s),
    .head_addr_o   (head_addr_s),
    .head_data_o   (head_data_s),
    .hit_o         (hit_s),
    .hit_data_o    (hit_data_s)
  );

  // Array write port, used only by drains.
  always_ff @(posedge clock) begin
    if (pop_s) begin
      mem_q[head_addr_s] <= wr_word_s;
    end
  end

  // Load response: forwarded data wins over the array.
  always_comb begin
    q_dmem_d  = q_dmem_q;
    q_valid_d = 1'b0;
    if (load_s) begin
      q_valid_d = 1'b1;
      if (hit_s) begin
        q_dmem_d = hit_data_s;
      end else begin
        q_dmem_d = rd_word_s[DATA_WIDTH-1:0];
      end
    end else begin
      q_valid_d = 1'b0;
    end
  end

  // Response registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      q_dmem_q  <= '0;
      q_valid_q <= 1'b0;
    end else begin
      q_dmem_q  <= q_dmem_d;
      q_valid_q <= q_valid_d;
    end
  end

  assign bus.q_dmem  = q_dmem_q;
  assign bus.q_valid = q_valid_q;

`ifdef DMEM_PARITY_EN
  logic perr_q, perr_d;

  // Only array-sourced loads can report a parity mismatch.
  always_comb begin
    perr_d = 1'b0;
    if (load_s && !hit_s) begin
      perr_d = even_parity(rd_word_s[DATA_WIDTH-1:0]) ^ rd_word_s[DATA_WIDTH];
    end else begin
      perr_d = 1'b0;
    end
  end

  // Parity error flag register.
  always_ff @(posedge clock) begin
    if (reset) begin
      perr_q <= 1'b0;
    end else begin
      perr_q <= perr_d;
    end
  end

  assign bus.parity_err = perr_q;
`else
  assign bus.parity_err = 1'b0;
`endif

endmodule
